// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - stall/flush sequencer for the 5-stage pipeline
// Mealy control decode over a RUN/MEM_WAIT/TIMEOUT FSM, plus saturating perf counters.
module pipeline_stall_controller #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             sram_ready,
  input  logic             perf_clear,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_exe_bubble,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_e;

  localparam logic [WAIT_W-1:0] MAX_WAIT_W = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;

  logic pc_freeze_c, if_id_freeze_c, if_id_flush_c, id_exe_bubble_c, pipe_freeze_c;

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    pc_freeze_c     = 1'b0;
    if_id_freeze_c  = 1'b0;
    if_id_flush_c   = 1'b0;
    id_exe_bubble_c = 1'b0;
    pipe_freeze_c   = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_access && !sram_ready) begin
          pc_freeze_c    = 1'b1;
          if_id_freeze_c = 1'b1;
          pipe_freeze_c  = 1'b1;
          state_d        = MEM_WAIT;
          wait_cnt_d     = WAIT_W'(1);
        end else if (hazard_detected) begin
          // A simultaneous taken branch is held in ID and re-presented later.
          pc_freeze_c     = 1'b1;
          if_id_freeze_c  = 1'b1;
          id_exe_bubble_c = 1'b1;
        end else if (branch_taken) begin
          if_id_flush_c = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (sram_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          pc_freeze_c    = 1'b1;
          if_id_freeze_c = 1'b1;
          pipe_freeze_c  = 1'b1;
          if (wait_cnt_q == MAX_WAIT_W) begin
            state_d = TIMEOUT;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      TIMEOUT: begin
        pc_freeze_c    = 1'b1;
        if_id_freeze_c = 1'b1;
        pipe_freeze_c  = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (perf_clear) begin
      stall_count_d = '0;
      flush_count_d = '0;
    end else begin
      if (pc_freeze_c && stall_count_q != CNT_MAX) begin
        stall_count_d = stall_count_q + CNT_W'(1);
      end
      if (if_id_flush_c && flush_count_q != CNT_MAX) begin
        flush_count_d = flush_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  // Gating with rst keeps every output low during reset even with live inputs.
  assign pc_freeze     = rst & pc_freeze_c;
  assign if_id_freeze  = rst & if_id_freeze_c;
  assign if_id_flush   = rst & if_id_flush_c;
  assign id_exe_bubble = rst & id_exe_bubble_c;
  assign pipe_freeze   = rst & pipe_freeze_c;
  assign mem_timeout   = rst & (state_q == TIMEOUT);
  assign stall_count   = stall_count_q;
  assign flush_count   = flush_count_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

  localparam int CNT_W = 4;
  // {pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, pipe_freeze, mem_timeout}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_HAZ  = 6'b110100;
  localparam logic [5:0] C_BR   = 6'b001000;
  localparam logic [5:0] C_MEM  = 6'b110010;
  localparam logic [5:0] C_TMO  = 6'b110011;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hazard_detected = 1'b0, branch_taken = 1'b0, mem_access = 1'b0;
  logic sram_ready = 1'b0, perf_clear = 1'b0;
  logic pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, pipe_freeze, mem_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic [5:0] ctl;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MAX_WAIT(15), .WAIT_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_access(mem_access), .sram_ready(sram_ready), .perf_clear(perf_clear),
    .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush),
    .id_exe_bubble(id_exe_bubble), .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  assign ctl = {pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, pipe_freeze, mem_timeout};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge: apply inputs, check Mealy outputs, advance one cycle.
  task automatic step(input logic h, input logic b, input logic m, input logic r,
                      input logic c, input logic [5:0] exp, input string tag);
    hazard_detected = h; branch_taken = b; mem_access = m; sram_ready = r; perf_clear = c;
    #2;
    check(tag, 32'(ctl), 32'(exp));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    hazard_detected = 1'b1; branch_taken = 1'b1; mem_access = 1'b1;
    sram_ready = 1'b1; perf_clear = 1'b1;
    #12;
    check("reset_ctl", 32'(ctl), 32'(C_NONE));
    check("reset_stall", 32'(stall_count), 0);
    check("reset_flush", 32'(flush_count), 0);
    @(negedge clk);
    hazard_detected = 0; branch_taken = 0; mem_access = 0; sram_ready = 0; perf_clear = 0;
    rst = 1'b1;
    @(negedge clk);
    step(0, 0, 0, 0, 0, C_NONE, "idle_after_reset");
    check("idle_stall", 32'(stall_count), 0);

    // Hazard suppresses a concurrent branch, which then flushes once the hazard clears.
    step(1, 1, 0, 0, 0, C_HAZ, "haz_c0");
    step(1, 1, 0, 0, 0, C_HAZ, "haz_c1");
    step(0, 1, 0, 0, 0, C_BR,  "branch_after_haz");
    step(0, 0, 0, 0, 0, C_NONE, "haz_idle");
    check("haz_stall_cnt", 32'(stall_count), 2);
    check("haz_flush_cnt", 32'(flush_count), 1);
    step(0, 0, 0, 0, 1, C_NONE, "clear1");
    check("clear1_stall", 32'(stall_count), 0);
    check("clear1_flush", 32'(flush_count), 0);

    // SRAM stall: ready arrives in the 4th cycle.
    step(0, 0, 1, 0, 0, C_MEM, "sram_c0");
    step(1, 1, 1, 0, 0, C_MEM, "sram_c1_ignore_id");
    step(0, 0, 1, 0, 0, C_MEM, "sram_c2");
    step(0, 0, 1, 1, 0, C_NONE, "sram_ready");
    check("sram_stall_cnt", 32'(stall_count), 3);
    check("sram_flush_cnt", 32'(flush_count), 0);
    step(1, 0, 0, 0, 0, C_HAZ, "back_in_run");
    step(0, 0, 1, 1, 0, C_NONE, "mem_ready_same_cycle");
    step(0, 0, 0, 0, 1, C_NONE, "clear2");
    check("clear2_stall", 32'(stall_count), 0);

    // Timeout: 16 frozen cycles then sticky mem_timeout; stall_count saturates at 15.
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, C_MEM, $sformatf("tmo_wait%0d", i));
    step(0, 0, 1, 0, 0, C_TMO, "tmo_c16");
    step(0, 0, 1, 1, 0, C_TMO, "tmo_late_ready");
    step(1, 1, 0, 0, 0, C_TMO, "tmo_ignore_id");
    check("tmo_stall_sat", 32'(stall_count), 15);
    step(0, 0, 0, 0, 1, C_TMO, "tmo_clear");
    check("tmo_clear_stall", 32'(stall_count), 0);
    step(0, 0, 0, 1, 0, C_TMO, "tmo_still");
    check("tmo_stall_inc", 32'(stall_count), 1);

    hazard_detected = 1; mem_access = 1;
    rst = 1'b0;
    #2;
    check("tmo_rst_ctl", 32'(ctl), 32'(C_NONE));
    @(negedge clk);
    hazard_detected = 0; mem_access = 0; sram_ready = 0;
    rst = 1'b1;
    @(negedge clk);
    step(0, 0, 0, 0, 0, C_NONE, "after_tmo_rst");

    // Saturation with 20 hazard cycles, then clear mid-stall.
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, C_HAZ, $sformatf("sat_haz%0d", i));
    check("sat_stall", 32'(stall_count), 15);
    check("sat_flush", 32'(flush_count), 0);
    step(1, 0, 0, 0, 1, C_HAZ, "sat_clear");
    check("sat_clear_stall", 32'(stall_count), 0);
    step(0, 1, 0, 0, 0, C_BR, "sat_branch");
    check("sat_flush_inc", 32'(flush_count), 1);

    // Reset in the 3rd MEM_WAIT cycle.
    step(0, 0, 1, 0, 0, C_MEM, "mid_run");
    step(0, 0, 1, 0, 0, C_MEM, "mid_mw1");
    step(0, 0, 1, 0, 0, C_MEM, "mid_mw2");
    #2;
    check("mid_mw3", 32'(ctl), 32'(C_MEM));
    rst = 1'b0;
    #1;
    check("mid_rst_ctl", 32'(ctl), 32'(C_NONE));
    check("mid_rst_stall", 32'(stall_count), 0);
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 1, 1, 0, C_NONE, "mid_post_nostall");
    step(0, 0, 1, 0, 0, C_MEM, "mid_post_run");
    step(0, 0, 0, 1, 0, C_NONE, "mid_post_ready");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage pipeline. It combines the ID-stage `hazard_detected` flag, the ID-stage taken-branch signal and the multi-cycle SRAM handshake in MEM. From these it drives PC/IF-ID freeze, IF-ID flush, ID-EXE bubble insertion and whole-back-end freeze. It also watches for SRAM accesses that never complete and keeps saturating stall/flush performance counters.

## Interface
- `MAX_WAIT`, 15: maximum `MEM_WAIT` cycles tolerated before timeout. Range 1..2^`WAIT_W`-1.
- `WAIT_W`, 4: width of the internal wait counter.
- `CNT_W`, 16: width of each performance counter.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `hazard_detected`  in  1  data hazard on the instruction in ID.
- `branch_taken`  in  1  branch resolved taken in ID this cycle.
- `mem_access`  in  1  instruction in MEM performs an SRAM read or write.
- `sram_ready`  in  1  SRAM access completes this cycle.
- `perf_clear`  in  1  synchronous clear of both counters.
- `pc_freeze`  out  1  hold PC.
- `if_id_freeze`  out  1  hold the IF/ID register.
- `if_id_flush`  out  1  load NOP into IF/ID.
- `id_exe_bubble`  out  1  load NOP (all enables 0) into ID/EXE.
- `pipe_freeze`  out  1  hold ID/EXE, EXE/MEM and MEM/WB registers.
- `mem_timeout`  out  1  sticky SRAM timeout flag.
- `stall_count`  out  `CNT_W`  cycles with `pc_freeze`=1, saturating.
- `flush_count`  out  `CNT_W`  cycles with `if_id_flush`=1, saturating.

## Operation
- States: `RUN`, `MEM_WAIT`, `TIMEOUT`.
- Registers: 2-bit state, `WAIT_W`-bit `wait_cnt`, and both counters.
- Control outputs are Mealy, decoded from the state and the current inputs.
- **RUN**, first matching rule wins:
  - **Memory stall.** Condition: `mem_access`=1 and `sram_ready`=0. Outputs: `pc_freeze`, `if_id_freeze` and `pipe_freeze` = 1; `id_exe_bubble` and `if_id_flush` = 0. Next state `MEM_WAIT`, `wait_cnt`←1.
  - **Data hazard.** Condition: `hazard_detected`=1. Outputs: `pc_freeze`, `if_id_freeze` and `id_exe_bubble` = 1; `pipe_freeze` = 0. A taken branch in the same cycle is suppressed (`if_id_flush`=0). It is re-presented once the hazard clears.
  - **Taken branch.** Condition: `branch_taken`=1. Output: `if_id_flush`=1, all freezes 0. The PC loads the target normally.
  - **Otherwise:** all control outputs 0.
  - A memory access with `sram_ready`=1 in the same cycle completes with no stall.
- **MEM_WAIT:**
  - `pc_freeze`, `if_id_freeze` and `pipe_freeze` = 1, except in a cycle where `sram_ready`=1.
  - `id_exe_bubble` and `if_id_flush` are always 0. `hazard_detected` and `branch_taken` are ignored because ID is frozen.
  - `sram_ready`=1: all freezes 0 this cycle, so the access retires. Next state `RUN`.
  - `sram_ready`=0 and `wait_cnt`==`MAX_WAIT`: next state `TIMEOUT`.
  - `sram_ready`=0 otherwise: `wait_cnt`+1.
- **TIMEOUT:**
  - `pc_freeze`, `if_id_freeze`, `pipe_freeze` and `mem_timeout` = 1; `id_exe_bubble` and `if_id_flush` = 0.
  - Absorbing state; only `rst` exits it.
  - Late `sram_ready` is ignored.
- **Counters:**
  - Each edge: if `perf_clear`, both counters ← 0. `perf_clear` has priority over increment.
  - Else `stall_count` += `pc_freeze`, and `flush_count` += `if_id_flush`.
  - Both hold at all-ones and do not wrap.
- `mem_timeout` is decoded from the registered state, so it has no input-to-output path.

## Timing
- `rst`=0, asynchronous and at any time:
  - state ← `RUN`, `wait_cnt` ← 0, counters ← 0.
  - All outputs are forced to 0 while `rst`=0, regardless of inputs.
  - Reset in the middle of `MEM_WAIT` or `TIMEOUT` aborts it; operation resumes in `RUN` on the first edge after release.
- Control outputs respond in the same cycle as their inputs, with zero latency.
- State, `wait_cnt` and counter updates become visible one edge later.
- A hazard stall lasts exactly as long as `hazard_detected`=1. Each hazard cycle inserts one bubble.
- SRAM stall length = cycles until `sram_ready`.
- Timeout timing:
  - Condition: `mem_access`=1 and `sram_ready`=0 held from cycle 0.
  - Cycles 0..`MAX_WAIT` are frozen, i.e. `MAX_WAIT`+1 stalled cycles.
  - `TIMEOUT` is entered at the edge ending cycle `MAX_WAIT`.
- `perf_clear` in cycle N: both counters read 0 in cycle N+1. That cycle's increment is lost.

## Test plan
- **Reset values.** Stimulus: apply `rst`=0 with all inputs at 1. Required: every output 0. After release, state `RUN` and counters 0.
- **Data hazard.** Stimulus: `hazard_detected`=1 for 2 cycles together with `branch_taken`=1, then `hazard_detected`=0 with `branch_taken`=1. Required: `pc_freeze`/`id_exe_bubble`=1 for 2 cycles with no flush, then `if_id_flush`=1 for 1 cycle. `stall_count`=2, `flush_count`=1.
- **SRAM stall.** Stimulus: `mem_access`=1 with `sram_ready` rising in the 4th cycle. Required: `pipe_freeze`=1 for 3 cycles, 0 in the ready cycle, and state back in `RUN`. `stall_count`=3.
- **SRAM timeout.** Stimulus: `MAX_WAIT`=15, `mem_access`=1, `sram_ready` held 0. Required: 16 frozen cycles, `mem_timeout`=1 from cycle 16. Freezes persist after a late `sram_ready`, and only `rst` clears them.
- **Saturation and clear.** Stimulus: `CNT_W`=4 with 20 hazard cycles, then `perf_clear` asserted during a stall. Required: `stall_count` holds at 15, then reads 0 the cycle after clear.
- **Reset mid-stall.** Stimulus: assert `rst` in the 3rd `MEM_WAIT` cycle. Required: outputs 0 immediately. After release, `mem_access`=1 and `sram_ready`=1 passes with no stall.
